// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/16-bit loads and stores onto a byte-wide memory port
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        reqWrite,
  input  logic        reqWide,
  input  logic [7:0]  reqAddress,
  input  logic [15:0] reqWriteData,
  output logic        busy,
  output logic        done,
  output logic [15:0] readData,
  output logic        memWriteEnable,
  output logic [7:0]  memAddress,
  output logic [7:0]  memWriteData,
  input  logic [7:0]  memData
);
  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;
  state_t state, next_state;
  logic wr, wide, acc, last;
  logic [7:0] addr, lo;
  logic [15:0] wdata;
  logic [1:0] cnt;
  assign acc = state == ACC_LO || state == ACC_HI;
  assign last = wr || cnt == 2'(READ_LATENCY);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr <= 1'b0;
      wide <= 1'b0;
      addr <= 8'h00;
      wdata <= 16'h0000;
      cnt <= 2'd0;
      lo <= 8'h00;
      readData <= 16'h0000;
    end else begin
      state <= next_state;
      if (state == IDLE && req) begin
        wr <= reqWrite;
        wide <= reqWide;
        addr <= reqAddress;
        wdata <= reqWriteData;
      end
      cnt <= (acc && !last) ? cnt + 2'd1 : 2'd0;
      if (acc && last && !wr) begin
        if (state == ACC_LO) lo <= memData;
        if (next_state == DONE) readData <= state == ACC_HI ? {memData, lo} : {8'h00, memData};
      end
    end
  end
  always_comb begin
    next_state = state == IDLE   ? (req ? ACC_LO : IDLE) :
                 state == ACC_LO ? (last ? (wide ? ACC_HI : DONE) : ACC_LO) :
                 state == ACC_HI ? (last ? DONE : ACC_HI) : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    memWriteEnable = acc && wr;
    memAddress = state == ACC_LO ? addr : state == ACC_HI ? addr + 8'd1 : 8'h00;
    memWriteData = !wr ? 8'h00 : state == ACC_LO ? wdata[7:0] : state == ACC_HI ? wdata[15:8] : 8'h00;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit at read latencies 1 and 0
module tb_load_store_unit;
  logic clk, reset, req1, req0, wr, wide;
  logic [7:0] addr;
  logic [15:0] wdata;
  logic busy1, done1, we1, busy0, done0, we0;
  logic [15:0] rd1, rd0;
  logic [7:0] ma1, wd1, md1, ma0, wd0, md0;
  logic [7:0] mem [256];
  int n_cmp, n_err, done_cnt, snap;

  load_store_unit #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .reqWrite(wr), .reqWide(wide),
    .reqAddress(addr), .reqWriteData(wdata), .busy(busy1), .done(done1),
    .readData(rd1), .memWriteEnable(we1), .memAddress(ma1),
    .memWriteData(wd1), .memData(md1));

  load_store_unit #(.READ_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .reqWrite(wr), .reqWide(wide),
    .reqAddress(addr), .reqWriteData(wdata), .busy(busy0), .done(done0),
    .readData(rd0), .memWriteEnable(we0), .memAddress(ma0),
    .memWriteData(wd0), .memData(md0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) md1 <= mem[ma1];
  assign md0 = mem[ma0];
  always @(posedge clk) if (done1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit which, input logic w, input logic wd, input logic [7:0] a, input logic [15:0] d);
    wr = w;
    wide = wd;
    addr = a;
    wdata = d;
    if (which) req1 = 1'b1;
    else req0 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    req0 = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    done_cnt = 0;
    reset = 1'b0;
    req1 = 1'b0;
    req0 = 1'b0;
    wr = 1'b0;
    wide = 1'b0;
    addr = 8'h00;
    wdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hCD;
    mem[8'h21] = 8'hEF;
    mem[8'h05] = 8'h7F;
    #3 reset = 1'b1;
    #1;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_rd", rd1, 16'h0000);
    check("rst_we", we1, 0);
    check("rst_ma", ma1, 8'h00);
    check("rst_wd", wd1, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(1, 1, 0, 8'h10, 16'h00AB);
    check("bs_c1_we", we1, 1);
    check("bs_c1_ma", ma1, 8'h10);
    check("bs_c1_wd", wd1, 8'hAB);
    check("bs_c1_busy", busy1, 1);
    @(negedge clk);
    check("bs_c2_done", done1, 1);
    check("bs_c2_we", we1, 0);
    check("bs_c2_rd", rd1, 16'h0000);
    @(negedge clk);
    check("bs_c3_busy", busy1, 0);
    check("bs_c3_done", done1, 0);

    issue(1, 1, 1, 8'hFF, 16'h1234);
    check("ws_c1_we", we1, 1);
    check("ws_c1_ma", ma1, 8'hFF);
    check("ws_c1_wd", wd1, 8'h34);
    @(negedge clk);
    check("ws_c2_we", we1, 1);
    check("ws_c2_ma", ma1, 8'h00);
    check("ws_c2_wd", wd1, 8'h12);
    @(negedge clk);
    check("ws_c3_done", done1, 1);
    check("ws_c3_we", we1, 0);
    check("ws_c3_ma", ma1, 8'h00);
    @(negedge clk);

    snap = done_cnt;
    issue(1, 0, 1, 8'h20, 16'h0000);
    check("wl_c1_ma", ma1, 8'h20);
    check("wl_c1_we", we1, 0);
    @(negedge clk);
    check("wl_c2_ma", ma1, 8'h20);
    check("wl_c2_we", we1, 0);
    check("wl_c2_done", done1, 0);
    req1 = 1'b1;
    wr = 1'b1;
    wide = 1'b0;
    addr = 8'h55;
    wdata = 16'h9999;
    @(negedge clk);
    check("wl_c3_ma", ma1, 8'h21);
    check("wl_c3_we", we1, 0);
    @(negedge clk);
    check("wl_c4_ma", ma1, 8'h21);
    check("wl_c4_we", we1, 0);
    check("wl_c4_done", done1, 0);
    @(negedge clk);
    check("wl_c5_done", done1, 1);
    check("wl_c5_rd", rd1, 16'hEFCD);
    check("wl_c5_we", we1, 0);
    req1 = 1'b0;
    @(negedge clk);
    check("wl_c6_busy", busy1, 0);
    check("wl_c6_done", done1, 0);
    @(negedge clk);
    @(negedge clk);
    check("wl_one_done", done_cnt - snap, 1);
    check("wl_rd_hold", rd1, 16'hEFCD);

    issue(0, 0, 1, 8'h20, 16'h0000);
    check("l0w_c1_ma", ma0, 8'h20);
    @(negedge clk);
    check("l0w_c2_ma", ma0, 8'h21);
    @(negedge clk);
    check("l0w_c3_done", done0, 1);
    check("l0w_c3_rd", rd0, 16'hEFCD);
    @(negedge clk);

    issue(0, 0, 0, 8'h05, 16'h0000);
    check("l0b_c1_ma", ma0, 8'h05);
    check("l0b_c1_done", done0, 0);
    @(negedge clk);
    check("l0b_c2_done", done0, 1);
    check("l0b_c2_rd", rd0, 16'h007F);
    @(negedge clk);
    check("l0b_c3_busy", busy0, 0);

    snap = done_cnt;
    issue(1, 1, 1, 8'h30, 16'hBEEF);
    @(negedge clk);
    check("ab_c2_we", we1, 1);
    check("ab_c2_ma", ma1, 8'h31);
    #1 reset = 1'b1;
    #1;
    check("ab_we", we1, 0);
    check("ab_busy", busy1, 0);
    check("ab_ma", ma1, 8'h00);
    check("ab_rd", rd1, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ab_no_done", done_cnt - snap, 0);
    issue(1, 1, 0, 8'h40, 16'h0066);
    check("ab_next_we", we1, 1);
    check("ab_next_ma", ma1, 8'h40);
    check("ab_next_wd", wd1, 8'h66);
    @(negedge clk);
    check("ab_next_done", done1, 1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
